// File: rtl/riscv_pipe_pkg.sv
// Shared encodings and default widths for the 5-stage RISC-V pipeline registers.
package riscv_pipe_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_RA_W   = 5;
    localparam int DEF_ALUC_W = 3;
    localparam int DEF_CNT_W  = 32;

    // Valid, RegWrite, ResSrc(2), MemWrite, Jal, Branch, Jalr, ALUSrc, sel
    localparam int CTRL_BASE_W = 10;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/pipe_field_reg.sv
// W-bit pipeline flop group: async reset to 0, sync clear beats enable; 1-cycle latency.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Clr,
    input  logic         En,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Q <= '0;
        end else if (Clr) begin
            Q <= '0;
        end else if (En) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register: 1-cycle latency, FlushE inserts a bubble, StallE holds.
// Optional perf counters (bubbles, stall cycles) under IDEX_PERF_CNT_EN.
module id_ex_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int RA_W   = DEF_RA_W,
    parameter int ALUC_W = DEF_ALUC_W
`ifdef IDEX_PERF_CNT_EN
    ,
    parameter int CNT_W  = DEF_CNT_W
`endif
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic [1:0]        ResSrcD,
    input  logic              MemWriteD,
    input  logic              JalD,
    input  logic              BranchD,
    input  logic              JalrD,
    input  logic              ALUSrcD,
    input  logic              selD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [RA_W-1:0]   Rs1D,
    input  logic [RA_W-1:0]   Rs2D,
    input  logic [RA_W-1:0]   RdD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic [1:0]        ResSrcE,
    output logic              MemWriteE,
    output logic              JalE,
    output logic              BranchE,
    output logic              JalrE,
    output logic              ALUSrcE,
    output logic              selE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [RA_W-1:0]   Rs1E,
    output logic [RA_W-1:0]   Rs2E,
    output logic [RA_W-1:0]   RdE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  FlushCntE,
    output logic [CNT_W-1:0]  StallCntE
`endif
);

    localparam int CTRL_W = CTRL_BASE_W + ALUC_W;

    logic loadEn;
    assign loadEn = ~StallE;

    // Clearing RdE on flush keeps forwarding comparators from matching a bubble.
    pipe_field_reg #(.W(CTRL_W)) u_ctrl (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(FlushE), .En(loadEn),
        .D({ValidD, RegWriteD, ResSrcD, MemWriteD, JalD, BranchD, JalrD, ALUSrcD, selD, ALUControlD}),
        .Q({ValidE, RegWriteE, ResSrcE, MemWriteE, JalE, BranchE, JalrE, ALUSrcE, selE, ALUControlE})
    );

    pipe_field_reg #(.W(3 * RA_W)) u_idx (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(FlushE), .En(loadEn),
        .D({Rs1D, Rs2D, RdD}),
        .Q({Rs1E, Rs2E, RdE})
    );

    pipe_field_reg #(.W(2 * XLEN)) u_ops (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(FlushE), .En(loadEn),
        .D({RD1D, RD2D}),
        .Q({RD1E, RD2E})
    );

    pipe_field_reg #(.W(3 * XLEN)) u_pcimm (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(FlushE), .En(loadEn),
        .D({PCD, PCPlus4D, ImmExtD}),
        .Q({PCE, PCPlus4E, ImmExtE})
    );

`ifdef IDEX_PERF_CNT_EN
    // Saturating counters; a stall that coincides with a flush is counted as a flush only.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            FlushCntE <= '0;
            StallCntE <= '0;
        end else begin
            if (FlushE && (FlushCntE != '1)) begin
                FlushCntE <= FlushCntE + 1'b1;
            end
            if (StallE && !FlushE && (StallCntE != '1)) begin
                StallCntE <= StallCntE + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;
    import riscv_pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic [1:0]  resSrc;
        logic        memWrite;
        logic        jal;
        logic        branch;
        logic        jalr;
        logic        aluSrc;
        logic        sel;
        logic [2:0]  aluCtl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        logic    stall;
        logic    flush;
        bundle_t d;
        bundle_t exp;
    } vec_t;

    logic    Clk;
    logic    Rst_n;
    logic    StallE;
    logic    FlushE;
    bundle_t dIn;
    bundle_t eOut;

    int nTests = 0;
    int nFail  = 0;
    bundle_t sb[$];

`ifdef IDEX_PERF_CNT_EN
    logic [3:0] FlushCntE;
    logic [3:0] StallCntE;
    id_ex_pipe_reg #(.CNT_W(4)) dut (
`else
    id_ex_pipe_reg dut (
`endif
        .Clk(Clk), .Rst_n(Rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(dIn.valid), .RegWriteD(dIn.regWrite), .ResSrcD(dIn.resSrc),
        .MemWriteD(dIn.memWrite), .JalD(dIn.jal), .BranchD(dIn.branch), .JalrD(dIn.jalr),
        .ALUSrcD(dIn.aluSrc), .selD(dIn.sel), .ALUControlD(dIn.aluCtl),
        .RD1D(dIn.rd1), .RD2D(dIn.rd2), .Rs1D(dIn.rs1), .Rs2D(dIn.rs2), .RdD(dIn.rd),
        .PCD(dIn.pc), .PCPlus4D(dIn.pcPlus4), .ImmExtD(dIn.imm),
        .ValidE(eOut.valid), .RegWriteE(eOut.regWrite), .ResSrcE(eOut.resSrc),
        .MemWriteE(eOut.memWrite), .JalE(eOut.jal), .BranchE(eOut.branch), .JalrE(eOut.jalr),
        .ALUSrcE(eOut.aluSrc), .selE(eOut.sel), .ALUControlE(eOut.aluCtl),
        .RD1E(eOut.rd1), .RD2E(eOut.rd2), .Rs1E(eOut.rs1), .Rs2E(eOut.rs2), .RdE(eOut.rd),
        .PCE(eOut.pc), .PCPlus4E(eOut.pcPlus4), .ImmExtE(eOut.imm)
`ifdef IDEX_PERF_CNT_EN
        , .FlushCntE(FlushCntE), .StallCntE(StallCntE)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic bundle_t pat(input logic [31:0] s);
        logic [191:0] t;
        t = {s, ~s, s ^ 32'h5A5A_5A5A, s + 32'h1111_1111, {s[15:0], s[31:16]}, s * 32'd3};
        return t[187:0];
    endfunction

    task automatic chk(input string name, input bundle_t act, input bundle_t exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive between edges, score one edge later.
    task automatic step(input logic st, input logic fl, input bundle_t d, input bundle_t exp,
                        input string name);
        bundle_t want;
        @(negedge Clk);
        StallE = st;
        FlushE = fl;
        dIn    = d;
        sb.push_back(exp);
        @(posedge Clk);
        #1;
        want = sb.pop_front();
        chk(name, eOut, want);
    endtask

    vec_t    tbl[10];
    bundle_t ones, zero, a, b, c, d4, inv;

    initial begin
        ones = '1;
        zero = '0;

        a          = pat(32'h0BAD_F00D);
        a.valid    = 1'b1;
        a.regWrite = 1'b1;
        a.rd       = 5'd7;
        a.rd1      = 32'h1234_5678;
        a.resSrc   = RES_ALU;
        a.aluCtl   = ALU_ADD;
        b          = pat(32'hCAFE_0001);
        b.valid    = 1'b1;
        b.resSrc   = RES_MEM;
        b.aluCtl   = ALU_SUB;
        c          = pat(32'h7777_3210);
        c.valid    = 1'b1;
        c.regWrite = 1'b1;
        c.memWrite = 1'b1;
        c.rd       = 5'd7;
        c.resSrc   = RES_PC4;
        c.aluCtl   = ALU_OR;
        d4         = pat(32'h0000_0042);
        d4.aluCtl  = ALU_AND;
        inv        = pat(32'hFFFF_0F0F);
        inv.valid  = 1'b0;
        inv.aluCtl = ALU_SLT;

        tbl[0] = '{1'b0, 1'b0, a,    a};
        tbl[1] = '{1'b0, 1'b0, b,    b};
        tbl[2] = '{1'b1, 1'b0, c,    b};
        tbl[3] = '{1'b1, 1'b0, d4,   b};
        tbl[4] = '{1'b1, 1'b0, a,    b};
        tbl[5] = '{1'b0, 1'b0, c,    c};
        tbl[6] = '{1'b1, 1'b1, d4,   zero};
        tbl[7] = '{1'b0, 1'b1, a,    zero};
        tbl[8] = '{1'b0, 1'b0, inv,  inv};
        tbl[9] = '{1'b0, 1'b0, ones, ones};

        // Reset with all-ones inputs: outputs held at zero across edges.
        Rst_n  = 1'b0;
        StallE = 1'b1;
        FlushE = 1'b0;
        dIn    = ones;
        #2;
        chk("reset_immediate", eOut, zero);
        @(posedge Clk);
        #1;
        chk("reset_through_edge", eOut, zero);
        @(negedge Clk);
        Rst_n  = 1'b1;
        StallE = 1'b0;
        chk("reset_release_before_edge", eOut, zero);
`ifdef IDEX_PERF_CNT_EN
        chkn("reset_flush_cnt", {28'd0, FlushCntE}, 32'd0);
        chkn("reset_stall_cnt", {28'd0, StallCntE}, 32'd0);
`endif
        step(1'b0, 1'b0, ones, ones, "first_load_ones");
        chkn("first_load_rd1", eOut.rd1, 32'hFFFF_FFFF);
        chkn("first_load_rd", {27'd0, eOut.rd}, 32'h1F);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].stall, tbl[i].flush, tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Flush over stall with a live writeback in E.
        step(1'b0, 1'b0, a, a, "pre_flush_load");
        chkn("pre_flush_rd", {27'd0, eOut.rd}, 32'd7);
        step(1'b1, 1'b1, c, zero, "flush_over_stall");
        chkn("flush_regwrite", {31'd0, eOut.regWrite}, 32'd0);
        chkn("flush_rd", {27'd0, eOut.rd}, 32'd0);
        chkn("flush_valid", {31'd0, eOut.valid}, 32'd0);
        chkn("flush_memwrite", {31'd0, eOut.memWrite}, 32'd0);

        // Async reset in the middle of a stall clears E before the next edge.
        step(1'b0, 1'b0, c, c, "pre_async_load");
        step(1'b1, 1'b0, a, c, "pre_async_stall");
        #3;
        Rst_n = 1'b0;
        #1;
        chk("async_reset_mid_stall", eOut, zero);
        @(posedge Clk);
        #1;
        chk("async_reset_hold", eOut, zero);
        @(negedge Clk);
        Rst_n  = 1'b1;
        StallE = 1'b0;
        step(1'b0, 1'b0, b, b, "post_async_load");

`ifdef IDEX_PERF_CNT_EN
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, pat(i), zero, "cnt_flush");
        end
        chkn("flush_cnt_saturated", {28'd0, FlushCntE}, 32'd15);
        chkn("stall_cnt_after_flushes", {28'd0, StallCntE}, 32'd0);
        step(1'b1, 1'b1, a, zero, "cnt_stall_flush0");
        step(1'b1, 1'b1, a, zero, "cnt_stall_flush1");
        chkn("stall_cnt_flush_priority", {28'd0, StallCntE}, 32'd0);
        step(1'b0, 1'b0, c, c, "cnt_reload");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, a, c, "cnt_stall");
        end
        chkn("stall_cnt_three", {28'd0, StallCntE}, 32'd3);
        chkn("flush_cnt_held", {28'd0, FlushCntE}, 32'd15);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
